uart_tx_frame_fsm: RTL and testbench
====================================

Name: uart_tx_frame_fsm

Overview:
Parametrised next-generation UART transmit framer. It combines the bit-sequencing state machine, the data shift register and serial line drive in one block.
- Runtime-selectable frame: data length, parity mode, stop-bit count and bit order.
- Optional triple-modular redundancy (TMR) with per-cycle scrubbing.
- Sits between the TX FIFO (first-word-fall-through) and the pad. Paced by the single-clk baud pulse from the baudrate generator.

Parameters:
MAX_DATA_BITS, 9, width of FiFoData_i and the shift register; legal range 5..9
TMR_EN, 1, 1 = triplicate state, counters and shift register with majority vote; 0 = single copy, TmrErr_o tied 0

Ports:
clk  input  1  system clock, at least 40 MHz
rst  input  1  asynchronous, active-low reset; release synchronous to clk
p_BaudSig_i  input  1  baud tick, one clk wide, one per bit time
p_FiFoEmpty_i  input  1  1 = TX FIFO empty
FiFoData_i  input  MAX_DATA_BITS  FIFO head word, valid while not empty
p_FiFoRead_o  output  1  one-clk pop strobe
DataBits_i  input  4  data bits per frame; values below 5 behave as 5, values above MAX_DATA_BITS behave as MAX_DATA_BITS
ParityMode_i  input  3  0 none, 1 even, 2 odd, 3 mark, 4 space, 5..7 none
StopBits_i  input  1  0 = one stop bit, 1 = two stop bits
MsbFirst_i  input  1  0 = LSB first, 1 = MSB first
Tx_o  output  1  serial line, idle high
State_o  output  5  voted one-hot state
BitCounter_o  output  4  voted data-bit index
Busy_o  output  1  1 when state is not INTERVAL
p_FrameDone_o  output  1  one-clk pulse at end of stop bit(s)
TmrErr_o  output  1  one-clk pulse when any TMR copy disagrees with the vote

Behaviour:
- States (one-hot): INTERVAL 00001, STARTBIT 00010, DATABITS 00100, PARITYBIT 01000, STOPBIT 10000.
- All transitions occur only on clk edges where p_BaudSig_i=1, except the reset and illegal-state cases below.
- Reset values:
  - State INTERVAL; counters 0; shift register 0.
  - Tx_o=1; p_FiFoRead_o, Busy_o, p_FrameDone_o, TmrErr_o all 0.
  - Reset asserted mid-frame aborts the frame and forces Tx_o=1 immediately (asynchronously).
- INTERVAL: if p_FiFoEmpty_i=0 and baud=1, go to STARTBIT.
  - In that same cycle: assert p_FiFoRead_o for exactly one clk, load FiFoData_i into the shift register, and latch DataBits/ParityMode/StopBits/MsbFirst.
  - Config changes mid-frame have no effect until the next frame.
- STARTBIT: Tx_o=0; on baud go to DATABITS.
- DATABITS: Tx_o = current bit.
  - LSB first: shift register bit 0, shifting right.
  - MSB first: bit (Nlat-1), shifting left.
  - Each baud: BitCounter increments and the register shifts.
  - On baud with BitCounter = Nlat-1: go to PARITYBIT if parity is enabled, else STOPBIT; BitCounter returns to 0.
- PARITYBIT: Tx_o = parity value, computed from the latched word masked to Nlat bits.
  - even: XOR of data; odd: inverted XOR; mark: 1; space: 0.
  - On baud go to STOPBIT.
- STOPBIT: Tx_o=1.
  - Stop counter counts baud ticks; exit after 1 tick (StopBits=0) or 2 ticks (StopBits=1).
  - On exit: go to INTERVAL and pulse p_FrameDone_o on the same edge.
- Back-to-back frames: the next frame can only start on a later baud tick, so the line gets at least one idle bit time between frames.
- Tx_o is registered and changes on the same edge as State_o.
- Bit-time count per frame: 1 + Nlat + P + S baud ticks from STARTBIT entry to INTERVAL.
- TMR (TMR_EN=1):
  - Every register has 3 copies; the bitwise majority vote drives outputs and next-state logic.
  - All copies are rewritten from the voted next value each clk (scrub).
  - TmrErr_o pulses for one clk in any cycle where a copy differs from the vote.
- A voted state that is not one of the five legal codes forces INTERVAL on the next clk, with Tx_o=1 and no FIFO read.
- BitCounter_o is 0 outside DATABITS.

Test Plan:
- 8N1, LSB first, FIFO holds 0xA5 -> one p_FiFoRead_o pulse; Tx_o per tick 0,1,0,1,0,0,1,0,1,1; p_FrameDone_o on the 10th tick.
- 7 data bits, even parity, 2 stop, word 0x41 -> data 1,0,0,0,0,0,1; parity 0; stop 1,1; total 11 ticks.
- 9 data bits, odd parity, MSB first, word 0x1FF -> data nine 1s; parity 0; frame is 12 ticks.
- FIFO empty with baud running -> remains INTERVAL, Tx_o=1, no p_FiFoRead_o. Two words queued -> two frames, each starting on a baud tick after the previous frame's p_FrameDone_o.
- TMR: force one copy of the state to STOPBIT mid-DATABITS -> TmrErr_o pulses once, frame bits unchanged, copies scrubbed. Force the voted state to 00011 -> INTERVAL next clk.
- Assert rst during the 4th data bit -> Tx_o=1 and State_o=00001 immediately. After release, the next non-empty FIFO plus baud tick starts a clean frame.

Source files
------------

// File: rtl/uart_tx_frame_fsm.sv
// ---------------------------------------------------------------------------
// uart_tx_frame_fsm
//
// UART transmit framer: bit-sequencing FSM, data shift register and the
// registered serial line driver in one block. It pops words from a
// first-word-fall-through TX FIFO and serialises them as
// start / data / optional parity / one or two stop bits, advancing one bit
// per baud tick. The frame format is sampled when a word is popped, so
// configuration changes mid-frame only affect the next frame.
//
// With TMR_EN != 0 every register exists three times. The bitwise majority
// vote drives the outputs and the next-state logic, and all three copies are
// rewritten from the voted next value every clock, which scrubs single-copy
// upsets within one cycle.
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-low reset
//   p_BaudSig_i    one-clk baud tick, one per bit time
//   p_FiFoEmpty_i  TX FIFO empty flag
//   FiFoData_i     FIFO head word (valid while not empty)
//   p_FiFoRead_o   one-clk pop strobe, asserted in the cycle a frame starts
//   DataBits_i     data bits per frame, clamped to 5..MAX_DATA_BITS
//   ParityMode_i   0 none, 1 even, 2 odd, 3 mark, 4 space, 5..7 none
//   StopBits_i     0 one stop bit, 1 two stop bits
//   MsbFirst_i     0 LSB first, 1 MSB first
//   Tx_o           serial line, idle high
//   State_o        voted one-hot state
//   BitCounter_o   voted data-bit index, 0 outside DATABITS
//   Busy_o         1 whenever the state is not INTERVAL
//   p_FrameDone_o  one-clk pulse after the last stop bit
//   TmrErr_o       one-clk pulse after a cycle in which a copy disagreed
// ---------------------------------------------------------------------------
module uart_tx_frame_fsm #(
    parameter int MAX_DATA_BITS = 9,
    parameter int TMR_EN        = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     p_BaudSig_i,
    input  logic                     p_FiFoEmpty_i,
    input  logic [MAX_DATA_BITS-1:0] FiFoData_i,
    output logic                     p_FiFoRead_o,
    input  logic [3:0]               DataBits_i,
    input  logic [2:0]               ParityMode_i,
    input  logic                     StopBits_i,
    input  logic                     MsbFirst_i,
    output logic                     Tx_o,
    output logic [4:0]               State_o,
    output logic [3:0]               BitCounter_o,
    output logic                     Busy_o,
    output logic                     p_FrameDone_o,
    output logic                     TmrErr_o
);

    typedef enum logic [4:0] {
        ST_INTERVAL  = 5'b00001,
        ST_STARTBIT  = 5'b00010,
        ST_DATABITS  = 5'b00100,
        ST_PARITYBIT = 5'b01000,
        ST_STOPBIT   = 5'b10000
    } state_t;

    // Register bundle, LSB first: state[4:0], bitcnt[8:5], stopcnt, stop2,
    // msb, par_en, par_bit, tx, done, nlat[19:16], shift register on top.
    localparam int          W      = 20 + MAX_DATA_BITS;
    localparam int          NC     = (TMR_EN != 0) ? 3 : 1;
    localparam logic [3:0]  MAXB   = 4'(MAX_DATA_BITS);
    localparam logic [W-1:0] RST_VAL = {{MAX_DATA_BITS{1'b0}}, 4'd0,
                                        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                        4'd0, 5'b00001};

    logic [W-1:0] r_regs [NC];
    logic         r_tmr_err;
    logic [W-1:0] w_vote;
    logic [W-1:0] w_next;
    logic         w_mismatch;
    logic         w_pop;

    genvar gi;

    // ---------------- redundancy: vote and disagreement detect -------------
    generate
        if (TMR_EN != 0) begin : g_tmr
            for (gi = 0; gi < W; gi++) begin : g_bit
                assign w_vote[gi] = (r_regs[0][gi] & r_regs[1][gi]) |
                                    (r_regs[0][gi] & r_regs[2][gi]) |
                                    (r_regs[1][gi] & r_regs[2][gi]);
            end
            assign w_mismatch = |((r_regs[0] ^ w_vote) |
                                  (r_regs[1] ^ w_vote) |
                                  (r_regs[2] ^ w_vote));
        end else begin : g_single
            assign w_vote     = r_regs[0];
            assign w_mismatch = 1'b0;
        end
    endgenerate

    // All copies reload from the voted next value: this is the scrub.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NC; i++) begin
                r_regs[i] <= RST_VAL;
            end
            r_tmr_err <= 1'b0;
        end else begin
            for (int i = 0; i < NC; i++) begin
                r_regs[i] <= w_next;
            end
            r_tmr_err <= w_mismatch;
        end
    end

    // ---------------- voted fields ----------------
    logic [MAX_DATA_BITS-1:0] w_v_sh;
    logic [3:0]               w_v_nlat;
    logic                     w_v_done;
    logic                     w_v_tx;
    logic                     w_v_par_bit;
    logic                     w_v_par_en;
    logic                     w_v_msb;
    logic                     w_v_stop2;
    logic                     w_v_stopcnt;
    logic [3:0]               w_v_bitcnt;
    logic [4:0]               w_v_state;

    assign {w_v_sh, w_v_nlat, w_v_done, w_v_tx, w_v_par_bit, w_v_par_en,
            w_v_msb, w_v_stop2, w_v_stopcnt, w_v_bitcnt, w_v_state} = w_vote;

    // ---------------- next-value fields ----------------
    logic [MAX_DATA_BITS-1:0] w_n_sh;
    logic [3:0]               w_n_nlat;
    logic                     w_n_done;
    logic                     w_n_tx;
    logic                     w_n_par_bit;
    logic                     w_n_par_en;
    logic                     w_n_msb;
    logic                     w_n_stop2;
    logic                     w_n_stopcnt;
    logic [3:0]               w_n_bitcnt;
    state_t                   w_n_state;

    assign w_next = {w_n_sh, w_n_nlat, w_n_done, w_n_tx, w_n_par_bit, w_n_par_en,
                     w_n_msb, w_n_stop2, w_n_stopcnt, w_n_bitcnt, w_n_state};

    // ---------------- frame-start helpers (new word from the FIFO) ---------
    logic [3:0]               w_cfg_nbits;
    logic [MAX_DATA_BITS-1:0] w_cfg_mask;
    logic                     w_cfg_xor;
    logic                     w_cfg_par_en;
    logic                     w_cfg_par_bit;

    always_comb begin
        w_cfg_nbits = DataBits_i;
        if (DataBits_i < 4'd5) begin
            w_cfg_nbits = 4'd5;
        end else if (DataBits_i > MAXB) begin
            w_cfg_nbits = MAXB;
        end
    end

    for (gi = 0; gi < MAX_DATA_BITS; gi++) begin : g_mask
        assign w_cfg_mask[gi] = (4'(gi) < w_cfg_nbits);
    end

    // Parity is resolved at load time because the shift register is
    // consumed while the data bits go out.
    assign w_cfg_xor = ^(FiFoData_i & w_cfg_mask);

    always_comb begin
        w_cfg_par_en  = 1'b1;
        w_cfg_par_bit = 1'b0;
        case (ParityMode_i)
            3'd1:    w_cfg_par_bit = w_cfg_xor;
            3'd2:    w_cfg_par_bit = ~w_cfg_xor;
            3'd3:    w_cfg_par_bit = 1'b1;
            3'd4:    w_cfg_par_bit = 1'b0;
            default: w_cfg_par_en  = 1'b0;
        endcase
    end

    // Bit currently at the output end of the register: bit 0 when LSB
    // first, bit nbits-1 when MSB first (the register shifts left then).
    function automatic logic pick_bit(input logic [MAX_DATA_BITS-1:0] sh,
                                      input logic msb, input logic [3:0] nbits);
        logic [MAX_DATA_BITS-1:0] tmp;
        tmp = sh >> (nbits - 4'd1);
        return msb ? tmp[0] : sh[0];
    endfunction

    logic [MAX_DATA_BITS-1:0] w_sh_shifted;
    assign w_sh_shifted = w_v_msb ? (w_v_sh << 1) : (w_v_sh >> 1);

    // ---------------- next-state / next-output logic ----------------
    always_comb begin
        w_n_state   = state_t'(w_v_state);
        w_n_sh      = w_v_sh;
        w_n_nlat    = w_v_nlat;
        w_n_done    = 1'b0;
        w_n_tx      = w_v_tx;
        w_n_par_bit = w_v_par_bit;
        w_n_par_en  = w_v_par_en;
        w_n_msb     = w_v_msb;
        w_n_stop2   = w_v_stop2;
        w_n_stopcnt = w_v_stopcnt;
        w_n_bitcnt  = w_v_bitcnt;
        w_pop       = 1'b0;

        case (w_v_state)
            ST_INTERVAL: begin
                w_n_tx      = 1'b1;
                w_n_bitcnt  = 4'd0;
                w_n_stopcnt = 1'b0;
                if (p_BaudSig_i && !p_FiFoEmpty_i) begin
                    w_pop       = 1'b1;
                    w_n_state   = ST_STARTBIT;
                    w_n_sh      = FiFoData_i;
                    w_n_nlat    = w_cfg_nbits;
                    w_n_par_en  = w_cfg_par_en;
                    w_n_par_bit = w_cfg_par_bit;
                    w_n_stop2   = StopBits_i;
                    w_n_msb     = MsbFirst_i;
                    w_n_tx      = 1'b0;
                end
            end
            ST_STARTBIT: begin
                if (p_BaudSig_i) begin
                    w_n_state = ST_DATABITS;
                    w_n_tx    = pick_bit(w_v_sh, w_v_msb, w_v_nlat);
                end
            end
            ST_DATABITS: begin
                if (p_BaudSig_i) begin
                    w_n_sh = w_sh_shifted;
                    if (w_v_bitcnt == w_v_nlat - 4'd1) begin
                        w_n_bitcnt = 4'd0;
                        if (w_v_par_en) begin
                            w_n_state = ST_PARITYBIT;
                            w_n_tx    = w_v_par_bit;
                        end else begin
                            w_n_state = ST_STOPBIT;
                            w_n_tx    = 1'b1;
                        end
                    end else begin
                        w_n_bitcnt = w_v_bitcnt + 4'd1;
                        w_n_tx     = pick_bit(w_sh_shifted, w_v_msb, w_v_nlat);
                    end
                end
            end
            ST_PARITYBIT: begin
                if (p_BaudSig_i) begin
                    w_n_state = ST_STOPBIT;
                    w_n_tx    = 1'b1;
                end
            end
            ST_STOPBIT: begin
                w_n_tx = 1'b1;
                if (p_BaudSig_i) begin
                    if (w_v_stop2 && !w_v_stopcnt) begin
                        w_n_stopcnt = 1'b1;
                    end else begin
                        w_n_stopcnt = 1'b0;
                        w_n_state   = ST_INTERVAL;
                        w_n_done    = 1'b1;
                    end
                end
            end
            default: begin
                // Corrupted voted state: recover to idle without waiting
                // for a baud tick and without touching the FIFO.
                w_n_state   = ST_INTERVAL;
                w_n_tx      = 1'b1;
                w_n_bitcnt  = 4'd0;
                w_n_stopcnt = 1'b0;
            end
        endcase
    end

    // ---------------- outputs ----------------
    // The pop strobe is combinational for the FWFT FIFO; gating with rst
    // keeps a word from being lost while the framer is held in reset.
    assign p_FiFoRead_o  = w_pop & rst;
    assign Tx_o          = w_v_tx;
    assign State_o       = w_v_state;
    assign BitCounter_o  = (w_v_state == ST_DATABITS) ? w_v_bitcnt : 4'd0;
    assign Busy_o        = (w_v_state != ST_INTERVAL);
    assign p_FrameDone_o = w_v_done;
    assign TmrErr_o      = r_tmr_err;

endmodule

// File: tb/tb_uart_tx_frame_fsm.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_frame_fsm
//
// Drives uart_tx_frame_fsm from a queue-backed FWFT FIFO model and a baud
// tick every BAUD clocks. Each enqueued word pushes its expected line
// sequence (computed from the frame rules) onto a scoreboard queue; frames
// captured from Tx_o at the baud ticks are popped and compared.
// ---------------------------------------------------------------------------
module tb_uart_tx_frame_fsm;

    localparam int BAUD = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud;
    logic       fifo_empty;
    logic [8:0] fifo_data;
    logic [3:0] data_bits;
    logic [2:0] par_mode;
    logic       stop_bits;
    logic       msb_first;
    logic       rd_o, tx_o, busy_o, done_o, tmr_o;
    logic [4:0] state_o;
    logic [3:0] bitcnt_o;

    always #5 clk = ~clk;

    uart_tx_frame_fsm #(.MAX_DATA_BITS(9), .TMR_EN(1)) dut (
        .clk(clk), .rst(rst), .p_BaudSig_i(baud), .p_FiFoEmpty_i(fifo_empty),
        .FiFoData_i(fifo_data), .p_FiFoRead_o(rd_o), .DataBits_i(data_bits),
        .ParityMode_i(par_mode), .StopBits_i(stop_bits), .MsbFirst_i(msb_first),
        .Tx_o(tx_o), .State_o(state_o), .BitCounter_o(bitcnt_o), .Busy_o(busy_o),
        .p_FrameDone_o(done_o), .TmrErr_o(tmr_o)
    );

    typedef struct {
        logic [15:0] bits;
        int          len;
    } frame_t;

    frame_t     exp_q[$];
    logic [8:0] fifo_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit baud_en = 1'b1;
    bit pop_pend = 1'b0;
    int rd_cnt = 0;
    int last_done_cyc = -1000;

    logic       s_rd, s_tx, s_done, s_tmr, s_busy;
    logic [4:0] s_state;
    logic [3:0] s_bitcnt;

    // Expected line values, one per bit time, from the frame rules.
    function automatic frame_t model_frame(input logic [8:0] w, input logic [3:0] db,
                                           input logic [2:0] pm, input logic sb,
                                           input logic mf);
        frame_t f;
        int     n;
        int     idx;
        logic   x;
        n = (db < 4'd5) ? 5 : ((db > 4'd9) ? 9 : int'(db));
        f.bits = '0;
        f.bits[0] = 1'b0;
        f.len = 1;
        x = 1'b0;
        for (int i = 0; i < n; i++) begin
            idx = mf ? (n - 1 - i) : i;
            f.bits[4'(f.len)] = w[4'(idx)];
            f.len++;
            x = x ^ w[4'(i)];
        end
        case (pm)
            3'd1: begin f.bits[4'(f.len)] = x;    f.len++; end
            3'd2: begin f.bits[4'(f.len)] = ~x;   f.len++; end
            3'd3: begin f.bits[4'(f.len)] = 1'b1; f.len++; end
            3'd4: begin f.bits[4'(f.len)] = 1'b0; f.len++; end
            default: ;
        endcase
        f.bits[4'(f.len)] = 1'b1;
        f.len++;
        if (sb) begin
            f.bits[4'(f.len)] = 1'b1;
            f.len++;
        end
        return f;
    endfunction

    // One clock: update FIFO/baud on the falling edge, sample outputs 2 ns
    // later (well before the next rising edge).
    task automatic tick();
        @(negedge clk);
        if (pop_pend) begin
            fifo_q.delete(0);
            pop_pend = 1'b0;
        end
        cyc++;
        baud = baud_en && ((cyc % BAUD) == 0);
        fifo_empty = (fifo_q.size() == 0);
        fifo_data = fifo_empty ? 9'h0 : fifo_q[0];
        #2;
        s_rd = rd_o; s_tx = tx_o; s_done = done_o; s_tmr = tmr_o;
        s_busy = busy_o; s_state = state_o; s_bitcnt = bitcnt_o;
        if (s_rd) begin
            pop_pend = 1'b1;
            rd_cnt++;
        end
        if (s_done) last_done_cyc = cyc;
    endtask

    task automatic enqueue(input logic [8:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(model_frame(w, data_bits, par_mode, stop_bits, msb_first));
    endtask

    // Waits for a frame start, records Tx_o at every baud tick until the
    // frame-done pulse. Optionally corrupts one TMR copy of the state or
    // changes the configuration after the frame has started.
    task automatic capture_frame(input int inj_tick, input bit chg_cfg,
                                 output logic [15:0] bits, output int len,
                                 output int rd_in_frame, output int start_cyc,
                                 output int tmr_pulses, output logic [4:0] scrub_state,
                                 output bit timeout);
        int k;
        int rd0;
        int inj_cyc;
        bits = '0; len = 0; tmr_pulses = 0; scrub_state = '0; timeout = 1'b0;
        rd_in_frame = 0; start_cyc = -1; inj_cyc = -1;
        k = 0;
        do begin
            tick();
            k++;
        end while (!s_rd && k < 400);
        if (!s_rd) begin
            timeout = 1'b1;
            return;
        end
        start_cyc = cyc;
        rd0 = rd_cnt;
        if (chg_cfg) begin
            data_bits = 4'd5; par_mode = 3'd3;
            stop_bits = ~stop_bits; msb_first = ~msb_first;
        end
        k = 0;
        while (!s_done && k < 300) begin
            tick();
            k++;
            if (s_tmr) tmr_pulses++;
            if (inj_cyc >= 0 && cyc == inj_cyc + 1) scrub_state = dut.r_regs[1][4:0];
            if (baud) begin
                if (len < 16) bits[4'(len)] = s_tx;
                len++;
            end else if (inj_tick > 0 && inj_cyc < 0 && len == inj_tick) begin
                dut.r_regs[1][4:0] = 5'b10000;
                inj_cyc = cyc;
            end
        end
        if (!s_done) timeout = 1'b1;
        rd_in_frame = rd_cnt - rd0 + 1;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        int rd_before;
        rst = 1'b0;
        data_bits = 4'd8; par_mode = 3'd0; stop_bits = 1'b0; msb_first = 1'b0;
        enqueue(9'h0A5);
        rd_before = rd_cnt;
        for (int i = 0; i < 12; i++) tick();
        total++; if (s_tx !== 1'b1) begin $display("FAIL reset_tx: got %b want 1", s_tx); bad++; end
        total++; if (s_state !== 5'b00001) begin $display("FAIL reset_state: got %b want 00001", s_state); bad++; end
        total++; if (s_busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", s_busy); bad++; end
        total++; if (s_done !== 1'b0) begin $display("FAIL reset_done: got %b want 0", s_done); bad++; end
        total++; if (s_tmr !== 1'b0) begin $display("FAIL reset_tmrerr: got %b want 0", s_tmr); bad++; end
        total++; if (s_bitcnt !== 4'd0) begin $display("FAIL reset_bitcnt: got %0d want 0", s_bitcnt); bad++; end
        total++; if (rd_cnt !== rd_before) begin $display("FAIL reset_no_read: got %0d reads want 0", rd_cnt - rd_before); bad++; end
        rst = 1'b1;
        $display("reset: released at cycle %0d", cyc);
    endtask

    // Runs one frame; the word is enqueued here unless already pending.
    task automatic test_frame_cfg(input string name, input bit do_enq, input logic [8:0] w,
                                  input logic [3:0] db, input logic [2:0] pm,
                                  input logic sb, input logic mf, input bit chg_cfg);
        logic [15:0] bits;
        logic [4:0]  ss;
        int          len, rdn, sc, tp;
        bit          to;
        frame_t      e;
        data_bits = db; par_mode = pm; stop_bits = sb; msb_first = mf;
        if (do_enq) enqueue(w);
        capture_frame(0, chg_cfg, bits, len, rdn, sc, tp, ss, to);
        e = exp_q.pop_front();
        total++; if (to) begin $display("FAIL %s_timeout: got timeout want frame", name); bad++; end
        total++; if (len !== e.len) begin $display("FAIL %s_len: got %0d want %0d", name, len, e.len); bad++; end
        total++; if (bits !== e.bits) begin $display("FAIL %s_bits: got %b want %b", name, bits, e.bits); bad++; end
        total++; if (rdn !== 1) begin $display("FAIL %s_reads: got %0d want 1", name, rdn); bad++; end
        $display("frame %s: word=%h ticks=%0d bits=%b", name, w, len, bits);
    endtask

    task automatic test_empty();
        for (int i = 0; i < 3 * BAUD; i++) begin
            tick();
            total++; if (s_rd !== 1'b0) begin $display("FAIL empty_read: got %b want 0", s_rd); bad++; end
            total++; if (s_tx !== 1'b1) begin $display("FAIL empty_tx: got %b want 1", s_tx); bad++; end
            total++; if (s_state !== 5'b00001) begin $display("FAIL empty_state: got %b want 00001", s_state); bad++; end
            total++; if (s_bitcnt !== 4'd0) begin $display("FAIL empty_bitcnt: got %0d want 0", s_bitcnt); bad++; end
        end
        $display("empty: %0d idle cycles checked", 3 * BAUD);
    endtask

    task automatic test_back_to_back();
        logic [15:0] bits;
        logic [4:0]  ss;
        int          len, rdn, sc, tp, done1;
        bit          to;
        frame_t      e;
        data_bits = 4'd8; par_mode = 3'd0; stop_bits = 1'b0; msb_first = 1'b0;
        enqueue(9'h03C);
        enqueue(9'h0C3);
        for (int f = 0; f < 2; f++) begin
            done1 = last_done_cyc;
            capture_frame(0, 1'b0, bits, len, rdn, sc, tp, ss, to);
            e = exp_q.pop_front();
            total++; if (to) begin $display("FAIL b2b_timeout: frame %0d got timeout want frame", f); bad++; end
            total++; if (bits !== e.bits) begin $display("FAIL b2b_bits: frame %0d got %b want %b", f, bits, e.bits); bad++; end
            total++; if (len !== e.len) begin $display("FAIL b2b_len: frame %0d got %0d want %0d", f, len, e.len); bad++; end
            if (f == 1) begin
                total++;
                if (sc - done1 < BAUD - 1) begin
                    $display("FAIL b2b_gap: got start %0d cycles after done want >= %0d", sc - done1, BAUD - 1);
                    bad++;
                end
            end
            $display("b2b frame %0d: start=%0d bits=%b", f, sc, bits);
        end
    endtask

    task automatic test_tmr_scrub();
        logic [15:0] bits;
        logic [4:0]  ss;
        int          len, rdn, sc, tp;
        bit          to;
        frame_t      e;
        data_bits = 4'd8; par_mode = 3'd0; stop_bits = 1'b0; msb_first = 1'b0;
        enqueue(9'h05A);
        capture_frame(3, 1'b0, bits, len, rdn, sc, tp, ss, to);
        e = exp_q.pop_front();
        total++; if (to) begin $display("FAIL tmr_timeout: got timeout want frame"); bad++; end
        total++; if (bits !== e.bits) begin $display("FAIL tmr_bits: got %b want %b", bits, e.bits); bad++; end
        total++; if (tp !== 1) begin $display("FAIL tmr_err_pulses: got %0d want 1", tp); bad++; end
        total++; if (ss !== 5'b00100) begin $display("FAIL tmr_scrub: got copy1 state %b want 00100", ss); bad++; end
        $display("tmr scrub: pulses=%0d copy1_after=%b bits=%b", tp, ss, bits);
    endtask

    task automatic test_illegal_state();
        int k = 0;
        while ((cyc % BAUD) != 2 && k < 20) begin
            tick();
            k++;
        end
        dut.r_regs[0][4:0] = 5'b00011;
        dut.r_regs[1][4:0] = 5'b00011;
        dut.r_regs[2][4:0] = 5'b00011;
        tick();
        total++; if (baud !== 1'b0) begin $display("FAIL illegal_setup: got baud %b want 0", baud); bad++; end
        total++; if (s_state !== 5'b00001) begin $display("FAIL illegal_state: got %b want 00001", s_state); bad++; end
        total++; if (s_tx !== 1'b1) begin $display("FAIL illegal_tx: got %b want 1", s_tx); bad++; end
        total++; if (s_busy !== 1'b0) begin $display("FAIL illegal_busy: got %b want 0", s_busy); bad++; end
        total++; if (s_rd !== 1'b0) begin $display("FAIL illegal_read: got %b want 0", s_rd); bad++; end
        $display("illegal state: recovered to %b", s_state);
    endtask

    task automatic test_reset_midframe();
        int k = 0;
        int nt = 0;
        frame_t e;
        data_bits = 4'd8; par_mode = 3'd0; stop_bits = 1'b0; msb_first = 1'b0;
        enqueue(9'h000);
        do begin
            tick();
            k++;
        end while (!s_rd && k < 400);
        total++; if (!s_rd) begin $display("FAIL midrst_start: got no read want read"); bad++; end
        k = 0;
        while (nt < 4 && k < 100) begin
            tick();
            k++;
            if (baud) nt++;
        end
        tick();
        total++; if (s_bitcnt !== 4'd3) begin $display("FAIL midrst_bitcnt: got %0d want 3", s_bitcnt); bad++; end
        total++; if (s_tx !== 1'b0) begin $display("FAIL midrst_tx_before: got %b want 0", s_tx); bad++; end
        rst = 1'b0;
        #1;
        total++; if (tx_o !== 1'b1) begin $display("FAIL midrst_tx: got %b want 1", tx_o); bad++; end
        total++; if (state_o !== 5'b00001) begin $display("FAIL midrst_state: got %b want 00001", state_o); bad++; end
        total++; if (busy_o !== 1'b0) begin $display("FAIL midrst_busy: got %b want 0", busy_o); bad++; end
        e = exp_q.pop_front();
        $display("mid-frame reset: aborted frame of %0d ticks", e.len);
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        test_frame_cfg("after_rst", 1'b1, 9'h096, 4'd8, 3'd1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b0; baud = 1'b0; fifo_empty = 1'b1; fifo_data = '0;
        data_bits = 4'd8; par_mode = 3'd0; stop_bits = 1'b0; msb_first = 1'b0;
        test_reset();
        test_frame_cfg("8n1_a5", 1'b0, 9'h0A5, 4'd8, 3'd0, 1'b0, 1'b0, 1'b0);
        test_frame_cfg("7e2_41", 1'b1, 9'h041, 4'd7, 3'd1, 1'b1, 1'b0, 1'b0);
        test_frame_cfg("9o1_msb", 1'b1, 9'h1FF, 4'd9, 3'd2, 1'b0, 1'b1, 1'b0);
        test_frame_cfg("clamp_lo", 1'b1, 9'h01E, 4'd3, 3'd1, 1'b0, 1'b0, 1'b0);
        test_frame_cfg("clamp_hi", 1'b1, 9'h155, 4'd15, 3'd0, 1'b1, 1'b0, 1'b0);
        test_frame_cfg("space_msb", 1'b1, 9'h0B1, 4'd8, 3'd4, 1'b0, 1'b1, 1'b0);
        test_frame_cfg("cfg_latch", 1'b1, 9'h02D, 4'd6, 3'd2, 1'b0, 1'b1, 1'b1);
        test_empty();
        test_back_to_back();
        test_tmr_scrub();
        test_illegal_state();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
